// File: rtl/fmap_bank_ring_if.sv
// fmap_bank_ring_if: producer/consumer bus of the multi-bank feature-map ring.
//   master : PE side (drives write/read requests, commit/release)
//   slave  : ring buffer (returns status, read data and error pulses)
// Signals:
//   wr_en/wr_addr/wr_data/wr_commit  producer requests
//   wr_ready/wr_bank                 producer status
//   rd_en/rd_addr/rd_release         consumer requests
//   rd_data/rd_valid/rd_ready/rd_bank consumer data and status
//   full_cnt, err_ovf, err_udf       ring occupancy and error pulses
interface fmap_bank_ring_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int NBANK  = 2
);
    localparam int BW = (NBANK > 2) ? $clog2(NBANK) : 1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic [BW-1:0]     wr_bank;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic              rd_ready;
    logic [BW-1:0]     rd_bank;

    logic [BW:0]       full_cnt;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank,
        input  full_cnt, err_ovf, err_udf
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank,
        output full_cnt, err_ovf, err_udf
    );
endinterface

// File: rtl/fmap_bank_ring.sv
// fmap_bank_ring: NBANK-deep circular ring of feature-map banks between a
// producer PE array and a consumer PE array. Ownership of a bank passes from
// producer to consumer on commit and back on release.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - fmap_bank_ring_if.slave (requests in, status/data/errors out)
module fmap_bank_ring #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int NBANK  = 2
) (
    input  logic                clk,
    input  logic                rst,
    fmap_bank_ring_if.slave     bus
);
    localparam int BW    = (NBANK > 2) ? $clog2(NBANK) : 1;
    localparam int DEPTH = NBANK << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [BW-1:0]     wp_q, wp_d;
    logic [BW-1:0]     rp_q, rp_d;
    logic [BW:0]       fc_q, fc_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_ovf_q, err_ovf_d;
    logic              err_udf_q, err_udf_d;

    logic wr_ready, rd_ready;
    logic wr_ok, cm_ok, rd_ok, rl_ok;

    // Explicit wrap at NBANK-1 so a 3-bank ring never reaches index 3.
    function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
        return (p == BW'(NBANK - 1)) ? '0 : p + BW'(1);
    endfunction

    assign wr_ready = (fc_q < (BW+1)'(NBANK));
    assign rd_ready = (fc_q != '0);

    // Acceptance uses the pre-update status, so a commit on a full ring is
    // rejected even if a release is accepted on the same edge.
    assign wr_ok = bus.wr_en      & wr_ready;
    assign cm_ok = bus.wr_commit  & wr_ready;
    assign rd_ok = bus.rd_en      & rd_ready;
    assign rl_ok = bus.rd_release & rd_ready;

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        fc_d      = fc_q;
        err_ovf_d = (bus.wr_en | bus.wr_commit)  & ~wr_ready;
        err_udf_d = (bus.rd_en | bus.rd_release) & ~rd_ready;
        if (cm_ok) wp_d = bump(wp_q);
        if (rl_ok) rp_d = bump(rp_q);
        case ({cm_ok, rl_ok})
            2'b10:   fc_d = fc_q + (BW+1)'(1);
            2'b01:   fc_d = fc_q - (BW+1)'(1);
            default: fc_d = fc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            fc_q      <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            fc_q      <= fc_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Storage: no reset so it maps onto block RAM. The write targets the
    // pre-commit bank, so a write issued with its commit lands in that bank.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wp_q, bus.wr_addr}] <= bus.wr_data;
    end

    // Read port: rd_data holds its value across rejected or idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) rd_data_q <= mem[{rp_q, bus.rd_addr}];
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.wr_bank  = wp_q;
    assign bus.rd_ready = rd_ready;
    assign bus.rd_bank  = rp_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full_cnt = fc_q;
    assign bus.err_ovf  = err_ovf_q;
    assign bus.err_udf  = err_udf_q;
endmodule
